// File: rtl/tl_debug_port.sv
// tl_debug_port: TileLink-UL debug/control slave. Doorbell, sticky exit
// register, freezable 64-bit cycle counter with coherent hi/lo reads, and a
// bank of byte-writable state words driven out as a flat vector.
module tl_debug_port #(
  parameter int          SOURCE_W    = 1,
  parameter int          NUM_WORDS   = 4,
  parameter int          ADDR_W      = $clog2(4*(NUM_WORDS+4)),
  // Counter value loaded on reset; nonzero only for bring-up experiments.
  parameter logic [63:0] CYCLE_RESET = 64'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              a_opcode,
  input  logic [2:0]              a_param,
  input  logic [3:0]              a_size,
  input  logic [SOURCE_W-1:0]     a_source,
  input  logic [ADDR_W-1:0]       a_address,
  input  logic [3:0]              a_mask,
  input  logic [31:0]             a_data,
  input  logic                    a_corrupt,
  input  logic                    a_valid,
  output logic                    a_ready,
  output logic [2:0]              d_opcode,
  output logic [1:0]              d_param,
  output logic [3:0]              d_size,
  output logic [SOURCE_W-1:0]     d_source,
  output logic                    d_denied,
  output logic [31:0]             d_data,
  output logic                    d_corrupt,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic                    callenv,
  output logic                    done,
  output logic [30:0]             exit_code,
  output logic [32*NUM_WORDS-1:0] state_o
);

  localparam int OFF_W    = ADDR_W - 2;
  localparam int NUM_REGS = 4 + NUM_WORDS;

  // Response channel registers (single-entry buffer)
  logic                d_valid_q;
  logic [2:0]          d_opcode_q;
  logic [3:0]          d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic                d_denied_q;
  logic [31:0]         d_data_q;

  // Register file state
  logic        callenv_q;
  logic [31:0] bell_q;
  logic        done_q;
  logic [30:0] exit_code_q;
  logic [63:0] cnt_q;
  logic [31:0] shadow_q;
  logic [31:0] state_q [NUM_WORDS];

  // Decode
  logic [OFF_W-1:0] off;
  logic [31:0]      off_ext;
  logic             is_get, is_put, legal, data_class, accept, wr_en, rd_en;
  logic [31:0]      rd_data;

  // Fields ignored by this slave; byte lane bits are not decoded.
  logic unused_ok;
  assign unused_ok = ^{a_param, a_corrupt, a_address[1:0]};

  assign a_ready = ~d_valid_q | d_ready;
  assign accept  = a_valid & a_ready;

  // Classify the request and build the read mux from pre-write values
  always_comb begin
    off        = a_address[ADDR_W-1:2];
    off_ext    = 32'(off);
    is_get     = (a_opcode == 3'd4);
    is_put     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    // Opcodes that carry a data response in TileLink (Arithmetic, Logical,
    // Get) answer with AccessAckData even when denied.
    data_class = (a_opcode == 3'd2) || (a_opcode == 3'd3) || (a_opcode == 3'd4);
    legal      = (is_get | is_put) && (a_size <= 4'd2) && (off_ext < 32'(NUM_REGS));
    wr_en      = accept & legal & is_put;
    rd_en      = accept & legal & is_get;
    rd_data    = 32'd0;
    case (off_ext)
      32'd0:   rd_data = bell_q;
      32'd1:   rd_data = {exit_code_q, done_q};
      32'd2:   rd_data = cnt_q[31:0];
      32'd3:   rd_data = shadow_q;
      default: begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (off_ext == 32'(k + 4)) rd_data = state_q[k];
        end
      end
    endcase
  end

  // Load the response on acceptance, retire it when the master takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= 3'd0;
      d_size_q   <= 4'd0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
      d_data_q   <= 32'd0;
    end else if (accept) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= data_class ? 3'd1 : 3'd0;
      d_size_q   <= a_size;
      d_source_q <= a_source;
      d_denied_q <= ~legal;
      d_data_q   <= rd_en ? rd_data : 32'd0;
    end else if (d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  // Doorbell, exit latch and counter snapshot commit on the acceptance edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      callenv_q   <= 1'b0;
      bell_q      <= 32'd0;
      done_q      <= 1'b0;
      exit_code_q <= 31'd0;
      shadow_q    <= 32'd0;
    end else begin
      callenv_q <= 1'b0;
      if (wr_en && off_ext == 32'd0) begin
        callenv_q <= 1'b1;
        bell_q    <= bell_q + 32'd1;
      end
      if (wr_en && off_ext == 32'd1 && !done_q && a_data[0]) begin
        done_q      <= 1'b1;
        exit_code_q <= a_data[31:1];
      end
      if (rd_en && off_ext == 32'd2) shadow_q <= cnt_q[63:32];
    end
  end

  // Free-running cycle counter, frozen once the exit flag is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_q <= CYCLE_RESET;
    else if (!done_q) cnt_q <= cnt_q + 64'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_state
      // Byte-masked write of state word gi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q[gi] <= 32'd0;
        end else if (wr_en && off_ext == 32'(gi + 4)) begin
          for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) state_q[gi][8*b +: 8] <= a_data[8*b +: 8];
          end
        end
      end
      assign state_o[32*gi +: 32] = state_q[gi];
    end
  endgenerate

  assign d_valid   = d_valid_q;
  assign d_opcode  = d_opcode_q;
  assign d_param   = 2'd0;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign d_corrupt = 1'b0;
  assign callenv   = callenv_q;
  assign done      = done_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_tl_debug_port.sv
// Testbench for tl_debug_port: directed vector table, hand-written multi-cycle
// sequences and a randomized phase, all checked against a cycle-level model.
module tb_tl_debug_port;

  localparam int          NW   = 5;
  localparam int          AW   = $clog2(4*(NW+4));
  localparam logic [63:0] CRST = 64'h0000_0001_FFFF_FF40;

  logic          clk, rst;
  logic [2:0]    a_opcode, a_param;
  logic [3:0]    a_size;
  logic [0:0]    a_source;
  logic [AW-1:0] a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          a_corrupt, a_valid, a_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [3:0]    d_size;
  logic [0:0]    d_source;
  logic          d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0]   d_data;
  logic          callenv, done;
  logic [30:0]   exit_code;
  logic [32*NW-1:0] state_o;

  tl_debug_port #(.SOURCE_W(1), .NUM_WORDS(NW), .CYCLE_RESET(CRST)) dut (
    .clk(clk), .rst(rst),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready),
    .callenv(callenv), .done(done), .exit_code(exit_code), .state_o(state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        den;
    logic [2:0]  dop;
    logic [31:0] data;
    logic [3:0]  size;
    logic [0:0]  src;
    logic        chk_dop;
    logic        chk_data;
  } resp_t;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_state [NW];
  logic [31:0] m_bell, m_shadow;
  logic        m_done;
  logic [30:0] m_exit;
  logic [63:0] m_cnt;
  logic        exp_callenv;
  resp_t       exp_q [$];

  // Observations from the most recent cycle
  logic        last_acc, last_fire;
  resp_t       last_obs;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_state[k] = 32'd0;
    m_bell = 0; m_shadow = 0; m_done = 0; m_exit = 0; m_cnt = CRST;
    exp_callenv = 0;
    exp_q.delete();
  endtask

  function automatic logic [32*NW-1:0] model_vec();
    logic [32*NW-1:0] v;
    for (int k = 0; k < NW; k++) v[32*k +: 32] = m_state[k];
    return v;
  endfunction

  function automatic logic is_legal(input logic [2:0] op, input logic [3:0] size, input int off);
    return (op == 3'd0 || op == 3'd1 || op == 3'd4) && size <= 4'd2 && off < 4 + NW;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    if (off == 0) return m_bell;
    if (off == 1) return {m_exit, m_done};
    if (off == 2) return m_cnt[31:0];
    if (off == 3) return m_shadow;
    return m_state[off-4];
  endfunction

  function automatic resp_t model_resp(input logic [2:0] op, input logic [3:0] size,
                                       input int off, input logic [0:0] src);
    resp_t r;
    logic  lg;
    lg         = is_legal(op, size, off);
    r.den      = !lg;
    r.dop      = (op == 3'd4) ? 3'd1 : 3'd0;
    r.chk_dop  = (op == 3'd0 || op == 3'd1 || op == 3'd4);
    r.chk_data = !lg || op == 3'd4;
    r.data     = (lg && op == 3'd4) ? model_read(off) : 32'd0;
    r.size     = size;
    r.src      = src;
    return r;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    resp_t       e;
    logic        acc, fire, pre_done, lg;
    logic [63:0] pre_cnt;
    logic [2:0]  op;
    logic [3:0]  size, mask;
    logic [31:0] data;
    int          off;
    @(negedge clk);
    chk("callenv", callenv, exp_callenv);
    chk("state_o", state_o, model_vec());
    chk("done", done, m_done);
    chk("exit_code", exit_code, m_exit);
    chk("d_valid", d_valid, exp_q.size() != 0);
    chk("a_ready", a_ready, exp_q.size() == 0 || d_ready);
    acc  = a_valid && a_ready;
    fire = d_valid && d_ready;
    last_acc  = acc;
    last_fire = fire;
    op = a_opcode; size = a_size; mask = a_mask; data = a_data;
    off = int'(a_address[AW-1:2]);
    if (fire && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_obs.den = d_denied; last_obs.dop = d_opcode; last_obs.data = d_data;
      last_obs.size = d_size; last_obs.src = d_source;
      chk("d_denied", d_denied, e.den);
      if (e.chk_dop)  chk("d_opcode", d_opcode, e.dop);
      if (e.chk_data) chk("d_data", d_data, e.data);
      chk("d_size", d_size, e.size);
      chk("d_source", d_source, e.src);
      chk("d_param", d_param, 2'd0);
      chk("d_corrupt", d_corrupt, 1'b0);
    end
    if (acc) exp_q.push_back(model_resp(op, size, off, a_source));
    pre_cnt  = m_cnt;
    pre_done = m_done;
    @(posedge clk);
    if (!pre_done) m_cnt = m_cnt + 64'd1;
    exp_callenv = 1'b0;
    if (acc) begin
      lg = is_legal(op, size, off);
      if (lg && op != 3'd4) begin
        if (off == 0) begin
          m_bell = m_bell + 1;
          exp_callenv = 1'b1;
        end else if (off == 1) begin
          if (!pre_done && data[0]) begin
            m_done = 1'b1;
            m_exit = data[31:1];
          end
        end else if (off >= 4) begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) m_state[off-4][8*b +: 8] = data[8*b +: 8];
        end
      end
      if (lg && op == 3'd4 && off == 2) m_shadow = pre_cnt[63:32];
    end
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [3:0] size, input int off,
                         input logic [3:0] mask, input logic [31:0] data);
    logic [AW-3:0] o;
    o         = (AW-2)'(off);
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = 1'($urandom_range(0, 1));
    a_address = {o, 2'($urandom_range(0, 3))};
    a_mask    = mask;
    a_data    = data;
    a_corrupt = 1'($urandom_range(0, 1));
  endtask

  // Issue one request with d_ready high and wait for its response
  task automatic xact(input logic [2:0] op, input logic [3:0] size, input int off,
                      input logic [3:0] mask, input logic [31:0] data, output resp_t r);
    int n;
    d_ready = 1'b1;
    set_req(op, size, off, mask, data);
    a_valid = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!last_acc && n < 20);
    if (!last_acc) chk("accept_timeout", 1, 0);
    a_valid = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!last_fire && n < 20);
    if (!last_fire) chk("response_timeout", 1, 0);
    r = last_obs;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  size;
    int          off;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        exp_den;
    logic        chk_dop;
    logic [2:0]  exp_dop;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    resp_t       r, r2;
    logic        c1, c2, c3;
    logic [31:0] lo, hi, lo2;
    logic [31:0] sd, sop;
    logic [2:0]  opt [9];
    int          off;

    vecs[0] = '{3'd0, 4'd2, 5,   4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0};
    vecs[1] = '{3'd4, 4'd2, 5,   4'hF, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{3'd0, 4'd2, 4,   4'hF, 32'h11223344, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0};
    vecs[3] = '{3'd1, 4'd2, 4,   4'h2, 32'h0000AB00, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0};
    vecs[4] = '{3'd4, 4'd2, 4,   4'hF, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 32'h1122AB44};
    vecs[5] = '{3'd4, 4'd2, 4+NW,4'hF, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 32'h0};
    vecs[6] = '{3'd2, 4'd2, 4,   4'hF, 32'h55555555, 1'b1, 1'b0, 3'd0, 1'b1, 32'h0};
    vecs[7] = '{3'd4, 4'd3, 4,   4'hF, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 32'h0};
    vecs[8] = '{3'd4, 4'd2, 4,   4'hF, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 32'h1122AB44};
    vecs[9] = '{3'd0, 4'd2, 3,   4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0};

    // Reset state
    rst = 1'b1; a_valid = 1'b0; d_ready = 1'b1;
    set_req(3'd4, 4'd2, 0, 4'hF, 32'h0);
    model_reset();
    last_acc = 0; last_fire = 0; last_obs = '{default: '0};
    repeat (3) @(negedge clk);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_callenv", callenv, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_exit_code", exit_code, 31'd0);
    chk("rst_state_o", state_o, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      xact(vecs[i].op, vecs[i].size, vecs[i].off, vecs[i].mask, vecs[i].data, r);
      $display("[TB] vec %0d op=%0d off=%0d den=%0d dop=%0d data=%h", i, vecs[i].op,
               vecs[i].off, r.den, r.dop, r.data);
      chk($sformatf("vec%0d_den", i), r.den, vecs[i].exp_den);
      if (vecs[i].chk_dop)  chk($sformatf("vec%0d_dop", i), r.dop, vecs[i].exp_dop);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), r.data, vecs[i].exp_data);
    end
    chk("state1_deadbeef", state_o[63:32], 32'hDEADBEEF);
    chk("state0_partial", state_o[31:0], 32'h1122AB44);

    // Back-to-back doorbell writes
    d_ready = 1'b1;
    set_req(3'd0, 4'd2, 0, 4'hF, 32'h0);
    a_valid = 1'b1;
    cycle(); c1 = callenv;
    cycle(); c2 = callenv;
    a_valid = 1'b0;
    cycle(); c3 = callenv;
    cycle();
    $display("[TB] doorbell pulses %0d %0d %0d", c1, c2, c3);
    chk("bell_pulse1", c1, 1'b1);
    chk("bell_pulse2", c2, 1'b1);
    chk("bell_pulse_end", c3, 1'b0);
    xact(3'd4, 4'd2, 0, 4'hF, 32'h0, r);
    $display("[TB] doorbell count %0d", r.data);
    chk("bell_count", r.data, 32'd2);

    // Backpressure: response held while d_ready is low
    d_ready = 1'b0;
    set_req(3'd4, 4'd2, 5, 4'hF, 32'h0);
    a_valid = 1'b1;
    cycle();
    chk("bp_first_accept", last_acc, 1'b1);
    set_req(3'd4, 4'd2, 4, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_no_accept", last_acc, 1'b0);
      chk("bp_a_ready", a_ready, 1'b0);
      chk("bp_d_valid", d_valid, 1'b1);
      chk("bp_d_data", d_data, 32'hDEADBEEF);
      chk("bp_d_opcode", d_opcode, 3'd1);
    end
    d_ready = 1'b1;
    cycle();
    chk("bp_accept_on_release", last_acc, 1'b1);
    a_valid = 1'b0;
    cycle();
    $display("[TB] backpressure second read data=%h", last_obs.data);
    chk("bp_second_data", last_obs.data, 32'h1122AB44);

    // Coherent counter reads across the low-word wrap
    for (int i = 0; i < 120; i++) begin
      xact(3'd4, 4'd2, 2, 4'hF, 32'h0, r);  lo = r.data;
      xact(3'd4, 4'd2, 3, 4'hF, 32'h0, r2); hi = r2.data;
      if (i % 20 == 0) $display("[TB] counter read %h_%h", hi, lo);
      chk("cycle_coherent", hi, lo[31] ? 32'd1 : 32'd2);
    end

    // Randomized traffic against the model (EXIT is never armed here)
    opt = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5, 3'd7};
    a_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(a_valid && !last_acc)) begin
        off = int'($urandom_range(0, (1 << (AW-2)) - 1));
        sop = $urandom_range(0, 8);
        sd  = $urandom;
        if (off == 1) sd[0] = 1'b0;
        set_req(opt[sop], 4'($urandom_range(0, 3) == 3 ? 3 : $urandom_range(0, 2)),
                off, 4'($urandom_range(0, 15)), sd);
        a_valid = ($urandom_range(0, 3) != 0);
      end
      d_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_fire && i % 300 == 0)
        $display("[TB] rand cycle %0d resp den=%0d data=%h", i, last_obs.den, last_obs.data);
    end
    a_valid = 1'b0; d_ready = 1'b1;
    repeat (3) cycle();

    // EXIT latch and counter freeze
    xact(3'd0, 4'd2, 1, 4'hF, 32'h0000002B, r);
    chk("exit_done", done, 1'b1);
    chk("exit_code", exit_code, 31'h15);
    xact(3'd4, 4'd2, 2, 4'hF, 32'h0, r); lo = r.data;
    repeat (5) cycle();
    xact(3'd4, 4'd2, 2, 4'hF, 32'h0, r); lo2 = r.data;
    $display("[TB] frozen counter %h %h", lo, lo2);
    chk("counter_frozen", lo2, lo);
    xact(3'd0, 4'd2, 1, 4'hF, 32'h00000077, r);
    chk("exit_sticky", exit_code, 31'h15);
    xact(3'd4, 4'd2, 1, 4'hF, 32'h0, r);
    $display("[TB] exit read %h", r.data);
    chk("exit_read", r.data, 32'h0000002B);

    // Reset with a response pending
    d_ready = 1'b0;
    set_req(3'd4, 4'd2, 5, 4'hF, 32'h0);
    a_valid = 1'b1;
    cycle();
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_d_valid", d_valid, 1'b0);
    chk("arst_state_o", state_o, '0);
    chk("arst_done", done, 1'b0);
    chk("arst_a_ready", a_ready, 1'b1);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    d_ready = 1'b1;
    repeat (2) cycle();
    xact(3'd4, 4'd2, 5, 4'hF, 32'h0, r);
    $display("[TB] post-reset state1 read %h", r.data);
    chk("post_rst_state1", r.data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
